// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the binary-to-BCD converter.
// Holds the state encoding, digit geometry and the minimum-digit calculation.
package bcd_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } bcd_state_t;

   localparam int BCD_DIGIT_W    = 4;
   localparam int ADD3_THRESHOLD = 5;
   localparam int ADD3_VALUE     = 3;

   // Decimal digits needed to represent 2^width-1.
   function automatic int min_bcd_digits(input int width);
      longint unsigned v;
      int              d;
      v = (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
      d = 1;
      for (int i = 0; i < 20; i++) begin
         if (v >= 64'd10) begin
            v = v / 64'd10;
            d = d + 1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/binary_to_bcd_if.sv
// Request/result bundle between a binary source and the BCD converter.
// master drives binary/start; slave (the converter) returns busy/done/bcd.
interface binary_to_bcd_if #(
   parameter int WIDTH  = 4,
   parameter int DIGITS = 2
);
   import bcd_pkg::*;

   logic [WIDTH-1:0]              binary;
   logic                          start;
   logic                          busy;
   logic                          done;
   logic [BCD_DIGIT_W*DIGITS-1:0] bcd;

   modport master (
      output binary,
      output start,
      input  busy,
      input  done,
      input  bcd
   );

   modport slave (
      input  binary,
      input  start,
      output busy,
      output done,
      output bcd
   );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] din,
   output logic [BCD_DIGIT_W-1:0] dout
);

   always_comb begin
      dout = din;
      if (din >= BCD_DIGIT_W'(ADD3_THRESHOLD)) begin
         dout = din + BCD_DIGIT_W'(ADD3_VALUE);
      end
   end

endmodule

// File: rtl/binary_to_bcd.sv
// Iterative binary-to-BCD converter, one double-dabble step per clock.
// bcd only updates on completion, so consumers never see partial results.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; binary captured on the accepting edge
//   SHIFT | one add-3/shift step per edge; last step loads bcd and done
module binary_to_bcd
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int DIGITS = 2
) (
   input  logic           clk,
   input  logic           reset,
   binary_to_bcd_if.slave bus
);

   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int CAT_W = BCD_W + WIDTH;
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   if (DIGITS < min_bcd_digits(WIDTH)) begin : g_digits_too_small
      $error("binary_to_bcd: DIGITS too small for WIDTH");
   end

   bcd_state_t       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BCD_W-1:0] dig_q, dig_d;
   logic [BCD_W-1:0] dig_adj;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic             done_q, done_d;
   logic [CAT_W-1:0] shifted;
   logic             last_iter;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (dig_q  [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .dout (dig_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // The top digit never overflows given the DIGITS bound, so the bit
   // shifted out of the concatenation is always zero.
   assign shifted   = {dig_adj, shreg_q} << 1;
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      dig_d   = dig_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shreg_d = bus.binary;
               dig_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shreg_d = shifted[WIDTH-1:0];
            dig_d   = shifted[WIDTH +: BCD_W];
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_iter) begin
               bcd_d   = shifted[WIDTH +: BCD_W];
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         dig_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         dig_q   <= dig_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = (state_q == SHIFT);
   assign bus.done = done_q;
   assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Bench for binary_to_bcd: a 4-bit/2-digit and an 8-bit/3-digit instance,
// checked every cycle against a cycle model with a queue of expected results.
module tb_binary_to_bcd;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   bit   live = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   binary_to_bcd_if #(.WIDTH(4), .DIGITS(2)) ifa ();
   binary_to_bcd_if #(.WIDTH(8), .DIGITS(3)) ifb ();

   binary_to_bcd #(.WIDTH(4), .DIGITS(2)) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (ifa)
   );

   binary_to_bcd #(.WIDTH(8), .DIGITS(3)) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (ifb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] r;
      r[3:0]  = 4'(v % 10);
      r[7:4]  = 4'((v / 10) % 10);
      r[11:8] = 4'((v / 100) % 10);
      return r;
   endfunction

   // cycle model: per channel busy countdown, done pulse, held bcd, scoreboard
   bit          m_busy [2] = '{0, 0};
   int          m_left [2] = '{0, 0};
   bit          m_done [2] = '{0, 0};
   logic [11:0] m_hold [2] = '{12'h0, 12'h0};
   logic [11:0] sb_a [$];
   logic [11:0] sb_b [$];

   always begin
      @(posedge clk);
      for (int ch = 0; ch < 2; ch++) begin
         logic rst_v, start_v;
         int   bin_v, w;
         rst_v   = (ch == 0) ? rst_a : rst_b;
         start_v = (ch == 0) ? ifa.start : ifb.start;
         bin_v   = (ch == 0) ? int'(ifa.binary) : int'(ifb.binary);
         w       = (ch == 0) ? 4 : 8;
         if (rst_v) begin
            m_busy[ch] = 0;
            m_left[ch] = 0;
            m_done[ch] = 0;
            m_hold[ch] = 12'h0;
            if (ch == 0) sb_a.delete(); else sb_b.delete();
         end else begin
            m_done[ch] = 0;
            if (!m_busy[ch]) begin
               if (start_v) begin
                  m_busy[ch] = 1;
                  m_left[ch] = w;
                  if (ch == 0) sb_a.push_back(to_bcd(bin_v));
                  else         sb_b.push_back(to_bcd(bin_v));
               end
            end else if (m_left[ch] == 1) begin
               m_busy[ch] = 0;
               m_done[ch] = 1;
            end else begin
               m_left[ch] = m_left[ch] - 1;
            end
         end
      end
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
         string       t;
         logic        busy_v, done_v;
         logic [11:0] bcd_v, exp;
         t      = (ch == 0) ? "a" : "b";
         busy_v = (ch == 0) ? ifa.busy : ifb.busy;
         done_v = (ch == 0) ? ifa.done : ifb.done;
         bcd_v  = (ch == 0) ? {4'h0, ifa.bcd} : ifb.bcd;
         chk({"busy_", t}, {11'h0, busy_v}, {11'h0, m_busy[ch]});
         chk({"done_", t}, {11'h0, done_v}, {11'h0, m_done[ch]});
         if (m_done[ch]) begin
            if (((ch == 0) ? sb_a.size() : sb_b.size()) == 0) begin
               chk({"sb_empty_", t}, 12'h1, 12'h0);
            end else begin
               exp = (ch == 0) ? sb_a.pop_front() : sb_b.pop_front();
               chk({"bcd_", t}, bcd_v, exp);
               m_hold[ch] = exp;
            end
         end else begin
            chk({"bcd_hold_", t}, bcd_v, m_hold[ch]);
         end
      end
   end

   // inputs change 1 time unit after the falling edge; live mimics a counter
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
         if (live) ifa.binary = ifa.binary + 4'd1;
      end
   endtask

   task automatic conv_a(input logic [3:0] v);
      ifa.binary = v;
      ifa.start  = 1'b1;
      step(1);
      ifa.start  = 1'b0;
      step(5);
   endtask

   task automatic conv_b(input logic [7:0] v);
      ifb.binary = v;
      ifb.start  = 1'b1;
      step(1);
      ifb.start  = 1'b0;
      step(9);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      ifa.binary = 4'd0;
      ifa.start  = 1'b0;
      ifb.binary = 8'd0;
      ifb.start  = 1'b0;
      step(2);
      rst_a = 1'b0;
      rst_b = 1'b0;
      step(2);

      conv_a(4'b1011);
      conv_a(4'd15);
      conv_a(4'd0);
      conv_a(4'd9);
      conv_a(4'd10);

      // binary keeps counting during SHIFT; result must be the captured value
      ifa.binary = 4'd3;
      live       = 1'b1;
      ifa.start  = 1'b1;
      step(1);
      ifa.start  = 1'b0;
      step(5);
      live       = 1'b0;

      // start while busy is ignored; start in the done cycle is accepted
      ifa.binary = 4'd13;
      ifa.start  = 1'b1;
      step(1);
      ifa.start  = 1'b0;
      ifa.binary = 4'd2;
      step(1);
      ifa.start  = 1'b1;
      step(1);
      ifa.start  = 1'b0;
      step(2);
      ifa.binary = 4'd12;
      ifa.start  = 1'b1;
      step(1);
      ifa.start  = 1'b0;
      step(6);

      // reset mid-conversion discards it, then a fresh conversion works
      ifa.binary = 4'd14;
      ifa.start  = 1'b1;
      step(1);
      ifa.start  = 1'b0;
      step(1);
      rst_a = 1'b1;
      step(1);
      rst_a = 1'b0;
      step(6);
      conv_a(4'd6);

      // start held high: conversions every 5 cycles
      ifa.binary = 4'd7;
      ifa.start  = 1'b1;
      step(20);
      ifa.start  = 1'b0;
      step(6);

      conv_b(8'd255);
      conv_b(8'd99);
      conv_b(8'd100);
      conv_b(8'd0);

      for (int i = 0; i < 4; i++) begin
         conv_a(4'($urandom_range(0, 15)));
         conv_b(8'($urandom_range(0, 255)));
      end

      step(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/binary_to_bcd.md
Name: binary_to_bcd

Overview:
Sequential binary-to-BCD converter using the iterative shift-add-3 (double-dabble) algorithm, one bit per clock. It sits directly downstream of binary_counter and consumes its `binary` count to produce packed BCD digits for display and monitor stages. A start/busy/done handshake lets the consumer sample the counter at chosen instants.

Parameters:
- WIDTH, 4, bit width of the `binary` input (matches the counter width).
- DIGITS, 2, number of BCD digits in the output. Must be at least the decimal digit count of 2^WIDTH-1. A smaller value is an elaboration-time error.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high reset.
- binary, input, WIDTH, unsigned value to convert; sampled only on the accepting edge.
- start, input, 1, conversion request; level-sampled on rising edges.
- busy, output, 1, high while a conversion is in progress.
- done, output, 1, one-cycle pulse: `bcd` has just been updated.
- bcd, output, 4*DIGITS, packed BCD result; digit 0 is in bits [3:0].

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - state=IDLE, busy=0, done=0, bcd=0.
  - Shift register, scratch digits and iteration counter are cleared.
  - Reset has priority over every other event, including mid-conversion; any in-flight conversion is discarded and bcd reads 0.
- States: IDLE, SHIFT. The state register and all outputs are registered.
- IDLE:
  - At an edge with start=1: capture `binary` into the shift register, clear the scratch digits, set count=0, go to SHIFT.
  - At an edge with start=0: stay in IDLE.
- SHIFT, one iteration per edge:
  - Every scratch digit that is >=5 gets +3 (combinational).
  - Then {digits, shift register} shifts left by one; the MSB of the shift register enters bit 0 of digit 0.
  - count increments on each iteration.
  - On the iteration where count==WIDTH-1: load the final digits into `bcd`, set done=1 for the next cycle, return to IDLE.
- Outputs and timing:
  - busy = (state==SHIFT).
  - done is forced to 0 at every edge other than the completing edge.
  - Latency: start accepted at edge N. SHIFT edges run N+1..N+WIDTH. busy is high between edge N and edge N+WIDTH. done is high for exactly the cycle after edge N+WIDTH, and `bcd` is valid from that same edge.
- `bcd` holds its last value until the next completion or reset; it never shows partial results.
- Changes on `binary` after the accepting edge have no effect on the result in flight.
- start=1 while busy is ignored: no queueing, no restart.
- start=1 in the done cycle is accepted (state is IDLE). Back-to-back conversions therefore run every WIDTH+1 cycles.
- start held high continuously produces repeated conversions at that rate.
- Width rules:
  - Scratch digits are 4 bits each; the add-3 result fits in 4 bits before the shift.
  - count width is $clog2(WIDTH) (minimum 1).
  - No overflow is possible given the DIGITS constraint.
- WIDTH=1 is legal: a single SHIFT iteration.

Decomposition:
- Shared package bcd_pkg:
  - state encoding constants IDLE/SHIFT;
  - BCD_DIGIT_W=4;
  - ADD3_THRESHOLD=5;
  - a function computing the minimum DIGITS for a given WIDTH, used by the elaboration check.
- One natural sub-module, bcd_digit_adj: combinational 4-bit in/out that adds 3 when the input is >=5. It is instantiated DIGITS times via generate.
- The FSM, shift register and counter stay in the top module.

Test Plan:
1. WIDTH=4, DIGITS=2, binary=4'b1011, start pulse at edge N -> busy=1 at edges N+1..N+4. At edge N+4, done=1 for one cycle and bcd=8'h11. Then done=0 and bcd holds 8'h11.
2. WIDTH=4: binary=15 -> bcd=8'h15; binary=0 -> bcd=8'h00; binary=9 -> bcd=8'h09; binary=10 -> bcd=8'h10. Drive `binary` from a live binary_counter and change it during SHIFT -> result equals the value captured at the accepting edge.
3. WIDTH=8, DIGITS=3: binary=255 -> bcd=12'h255 after 9 edges; binary=99 -> 12'h099; binary=100 -> 12'h100.
4. Assert start again at edge N+2 while busy -> ignored; single done at N+4. Assert start during the done cycle -> new conversion accepted; second done exactly 5 cycles after the first.
5. Reset=1 at edge N+2 mid-conversion -> busy=0, done=0, bcd=0 after that edge; no done pulse follows. A fresh start then converts correctly.
6. Hold start=1 for 20 cycles with binary=4'd7 (WIDTH=4) -> done pulses every 5 cycles, each with bcd=8'h07.
